// File: rtl/nios_system_pio_pkg.sv
// -----------------------------------------------------------------------------
// nios_system_pio_pkg
// Shared constants for the Nios II input PIO: Avalon register addresses and the
// edge-sensitivity encodings used by the EDGE_TYPE parameter.
// -----------------------------------------------------------------------------
package nios_system_pio_pkg;

    // Register map (word addresses on the 2-bit Avalon address bus)
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // Edge sensitivity encodings
    localparam int unsigned EDGE_RISE = 32'd0;
    localparam int unsigned EDGE_FALL = 32'd1;
    localparam int unsigned EDGE_ANY  = 32'd2;

    // Arming counter saturation value
    localparam logic [1:0] ARM_CNT_MAX = 2'd3;

endpackage : nios_system_pio_pkg

// File: rtl/nios_system_pio_in_if.sv
// -----------------------------------------------------------------------------
// nios_system_pio_in_if
// Avalon-MM slave bus bundle for the input PIO.
//   address    : register select (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : read data (32 bits), combinational from address
//   irq        : level interrupt, active high
// Modports: master (interconnect / CPU side), slave (PIO side).
// -----------------------------------------------------------------------------
interface nios_system_pio_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface : nios_system_pio_in_if

// File: rtl/nios_system_pio_in_sync.sv
// -----------------------------------------------------------------------------
// nios_system_pio_in_sync
// Input capture path for the PIO: brings the board pins into the clk domain
// (sync_q) and keeps a one-clock-delayed copy (prev_q) for edge detection.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_port      : raw board inputs (WIDTH bits)
//   sync_q       : synchronized input level
//   prev_q       : sync_q delayed by one clock
// Configuration macro NIOS_PIO_IN_SYNC_EN:
//   defined   -> two-flop synchronizer (meta stage, then sync_q)
//   undefined -> single register stage, for inputs already synchronous to clk
// -----------------------------------------------------------------------------
module nios_system_pio_in_sync #(
    parameter int unsigned WIDTH = 32'd10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] prev_q
);

`ifdef NIOS_PIO_IN_SYNC_EN
    // First flop may go metastable; only its resolved value is used downstream.
    logic [WIDTH-1:0] meta_r;

    // Two-flop synchronizer followed by the delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
            prev_q <= {WIDTH{1'b0}};
        end else begin
            meta_r <= in_port;
            sync_q <= meta_r;
            prev_q <= sync_q;
        end
    end
`else
    // Single sampling stage followed by the delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {WIDTH{1'b0}};
            prev_q <= {WIDTH{1'b0}};
        end else begin
            sync_q <= in_port;
            prev_q <= sync_q;
        end
    end
`endif

endmodule : nios_system_pio_in_sync

// File: rtl/nios_system_pio_in.sv
// -----------------------------------------------------------------------------
// nios_system_pio_in
// Avalon-MM slave input PIO for the Nios II system. Samples board inputs,
// captures per-bit edges and raises a level interrupt for unmasked captures.
//   clk, reset_n : system clock, asynchronous active-low reset
//   in_port      : board inputs (WIDTH bits)
//   bus          : Avalon slave (address, chipselect, write_n, writedata,
//                  readdata, irq)
// Registers: 0 DATA (RO), 1 reserved (reads 0), 2 IRQ_MASK (RW),
//            3 EDGE_CAP (RW1C, a new edge wins over a simultaneous clear).
// Configuration macro NIOS_PIO_IN_SYNC_EN selects the two-flop synchronizer;
// the arming threshold tracks the pipeline depth (3 with it, 2 without).
// -----------------------------------------------------------------------------
module nios_system_pio_in
    import nios_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 32'd10,
    parameter int unsigned EDGE_TYPE = 32'd2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    nios_system_pio_in_if.slave bus
);

`ifdef NIOS_PIO_IN_SYNC_EN
    localparam logic [1:0] ARM_THRESH = 2'd3;
`else
    localparam logic [1:0] ARM_THRESH = 2'd2;
`endif

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_raw_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] cap_clr_s;
    logic [WIDTH-1:0] wdata_s;
    logic             armed_s;
    logic             wr_en_s;
    logic             mask_wr_s;
    logic [31:0]      rd_data_s;
    logic             unused_wdata_s;

    logic [1:0]       arm_cnt_r;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_cap_r;

    nios_system_pio_in_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_q  (sync_q),
        .prev_q  (prev_q)
    );

    // Bits of writedata at WIDTH and above have no register behind them.
    assign wdata_s        = bus.writedata[WIDTH-1:0];
    assign unused_wdata_s = ^bus.writedata;

    // Arming counter: saturates at 3, restarts from 0 on every reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_r <= 2'd0;
        end else if (arm_cnt_r != ARM_CNT_MAX) begin
            arm_cnt_r <= arm_cnt_r + 2'd1;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    // Edge detection; gated until the sync/prev pipeline holds real samples
    always_comb begin
        edge_raw_s = {WIDTH{1'b0}};
        edge_s     = {WIDTH{1'b0}};
        armed_s    = (arm_cnt_r >= ARM_THRESH);
        case (EDGE_TYPE)
            EDGE_RISE: edge_raw_s = sync_q & ~prev_q;
            EDGE_FALL: edge_raw_s = ~sync_q & prev_q;
            EDGE_ANY:  edge_raw_s = sync_q ^ prev_q;
            default:   edge_raw_s = {WIDTH{1'b0}};
        endcase
        if (armed_s) begin
            edge_s = edge_raw_s;
        end else begin
            edge_s = {WIDTH{1'b0}};
        end
    end

    // Write decode: only the mask and edge-capture registers are writable
    always_comb begin
        wr_en_s   = bus.chipselect && !bus.write_n;
        mask_wr_s = 1'b0;
        cap_clr_s = {WIDTH{1'b0}};
        if (wr_en_s) begin
            case (bus.address)
                PIO_ADDR_MASK: mask_wr_s = 1'b1;
                PIO_ADDR_EDGE: cap_clr_s = wdata_s;
                default: begin
                    mask_wr_s = 1'b0;
                    cap_clr_s = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            mask_wr_s = 1'b0;
            cap_clr_s = {WIDTH{1'b0}};
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_r <= {WIDTH{1'b0}};
        end else if (mask_wr_s) begin
            irq_mask_r <= wdata_s;
        end else begin
            irq_mask_r <= irq_mask_r;
        end
    end

    // Edge capture: clear applied first, so a new edge in the same cycle wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_r <= {WIDTH{1'b0}};
        end else begin
            edge_cap_r <= (edge_cap_r & ~cap_clr_s) | edge_s;
        end
    end

    // Read mux, zero-extended to the 32-bit bus; no read side effects
    always_comb begin
        rd_data_s = 32'd0;
        case (bus.address)
            PIO_ADDR_DATA: rd_data_s[WIDTH-1:0] = sync_q;
            PIO_ADDR_RSVD: rd_data_s = 32'd0;
            PIO_ADDR_MASK: rd_data_s[WIDTH-1:0] = irq_mask_r;
            PIO_ADDR_EDGE: rd_data_s[WIDTH-1:0] = edge_cap_r;
            default:       rd_data_s = 32'd0;
        endcase
    end

    assign bus.readdata = rd_data_s;
    assign bus.irq      = |(edge_cap_r & irq_mask_r);

endmodule : nios_system_pio_in

// File: doc/nios_system_pio_in.md
# nios_system_pio_in

Avalon-MM slave input port: the read-side counterpart of the system's 8-bit output PIO (HEX driver). Samples board inputs (DE10-lite slide switches / push buttons) through a synchronizer, captures edges per bit, and raises a level interrupt to the Nios II. Sits on the system interconnect with zero-wait-state reads, beside the output PIOs.

## Interface
- `WIDTH`, 10: number of input bits, 1..32.
- `EDGE_TYPE`, 2: edge sensitivity, decoded as follows.
  - 0 = rising.
  - 1 = falling.
  - 2 = any.
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: asynchronous board inputs.
- `readdata` out 32: read data, combinational from address.
- `irq` out 1: level interrupt, active high.

## Operation
- Register map:
  - 0 = DATA, RO: synchronized input level.
  - 1 = reserved; reads 0, writes ignored.
  - 2 = IRQ_MASK, RW: bits [WIDTH-1:0].
  - 3 = EDGE_CAP, RW1C: writing 1 to a bit clears it.
- Input path: `in_port` → synchronizer (`sync_q`) → `prev_q`, with `prev_q` = `sync_q` delayed one clock.
- Edge detect per bit, combinational on `sync_q` vs `prev_q`:
  - rise = `sync_q & ~prev_q`.
  - fall = `~sync_q & prev_q`.
  - any = `sync_q ^ prev_q`.
- `edge_cap[i]` rules:
  - Set on a detected edge when armed.
  - Cleared by a write to address 3 with `writedata[i]`=1.
  - Set wins over clear in the same cycle.
- Arming: a 2-bit saturating counter `arm_cnt` counts clocks after reset. Edge detection is suppressed until `arm_cnt` reaches 3, so pipeline fill never causes a spurious capture.
- `irq` = OR-reduce(`edge_cap & irq_mask`), driven combinationally from registers.
- Writes take effect only when `chipselect` && !`write_n`.
  - Writes to addresses 0 and 1 are ignored.
  - `writedata` bits at WIDTH and above are ignored.
- `readdata` = selected register zero-extended to 32 bits. Reads have no side effects.

## Timing
- Reset values are 0 for all of the following:
  - `sync_q`, `prev_q`, `irq_mask`, `edge_cap`, `arm_cnt`.
  - Hence `readdata` = 0 for every address and `irq` = 0.
- Read latency: 0 cycles; `readdata` is valid in the same cycle as `address`.
- Latency with synchronizer, counting from the first clock edge after `in_port` changes (edge 1):
  - DATA reflects the change after edge 2.
  - `edge_cap` and `irq` assert after edge 3.
- Latency without synchronizer: DATA after edge 1; `edge_cap` and `irq` after edge 2.
- Register write effect:
  - `irq_mask` and `edge_cap` update at the clock edge ending the write cycle.
  - `irq` follows in the same cycle after that edge.
- Boundary cases:
  - Pulse shorter than one clock: may be missed; no guarantee.
  - Edge on an already-set bit: bit stays 1.
  - `reset_n` asserted mid-operation: all state clears immediately and arming restarts.
  - `in_port` held high through reset with `EDGE_TYPE`=0: no capture.

## Configuration
- `NIOS_PIO_IN_SYNC_EN` defined: two-flop synchronizer ahead of `sync_q`. Use this for asynchronous board pins.
- `NIOS_PIO_IN_SYNC_EN` undefined: single register stage. Use this for inputs already synchronous to `clk`.
  - Latencies reduce by one cycle.
  - The arming threshold becomes 2.

## Structure
- Package `nios_system_pio_pkg` holds:
  - Address constants `PIO_ADDR_DATA`/`_RSVD`/`_MASK`/`_EDGE` (0..3).
  - Edge-type constants `EDGE_RISE`/`EDGE_FALL`/`EDGE_ANY`.
- Sub-module `nios_system_pio_in_sync`: synchronizer plus `prev_q`, parameterized by WIDTH. Outputs `sync_q` and `prev_q`.

## Test plan
- Reset, then read addresses 0–3 → all read 0x00000000; `irq`=0 throughout.
- `in_port`=0x2A5 with the synchronizer enabled → DATA reads 0x2A5 after 2 clocks and reads 0 before that.
- EDGE_TYPE=0, mask=0x001, `in_port[0]` pulsed 0→1 for 4 clocks:
  - EDGE_CAP reads 0x001; `irq`=1 on the 3rd clock.
  - Write 0x001 to address 3 → EDGE_CAP=0, `irq`=0 next cycle.
- Clear write to bit 3 in the same cycle as a new bit-3 edge → EDGE_CAP bit 3 remains 1.
- EDGE_TYPE=2, mask=0, toggle bits 0 and 9:
  - EDGE_CAP=0x201 with `irq`=0.
  - Write mask 0x200 → `irq`=1 next cycle.
- `in_port`=0x3FF held through reset release with EDGE_TYPE=0 → EDGE_CAP stays 0.
  - Assert `reset_n` mid-capture → all registers read 0.
